// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared constants and types for the note recorder/player slice:
//   NOTE_W / DEPTH / ADDR_W : note code width, store depth, slot address width
//   HALF_W                  : width of the tone half-period counter
//   note_t, NOTE_*          : 3-bit note codes (0 = rest, 1..7 = C4..B4)
//   state_e                 : tone FSM states
//   half_cycles/half_reload : clock cycles per half period of each note
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int unsigned NOTE_W = 3;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned HALF_W = 17;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [HALF_W-1:0] half_t;

    localparam note_t NOTE_REST = 3'd0;
    localparam note_t NOTE_C4   = 3'd1;
    localparam note_t NOTE_D4   = 3'd2;
    localparam note_t NOTE_E4   = 3'd3;
    localparam note_t NOTE_F4   = 3'd4;
    localparam note_t NOTE_G4   = 3'd5;
    localparam note_t NOTE_A4   = 3'd6;
    localparam note_t NOTE_B4   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_TONE = 2'd2
    } state_e;

    // Half-period length in 50 MHz cycles. Rest maps to 1 so that the
    // reload value below never underflows; a rest never reaches TONE anyway.
    function automatic half_t half_cycles(input note_t n);
        half_t h;
        case (n)
            NOTE_C4: h = 17'd95556;
            NOTE_D4: h = 17'd85131;
            NOTE_E4: h = 17'd75843;
            NOTE_F4: h = 17'd71586;
            NOTE_G4: h = 17'd63776;
            NOTE_A4: h = 17'd56818;
            NOTE_B4: h = 17'd50619;
            default: h = 17'd1;
        endcase
        return h;
    endfunction

    // Counter reload value: the counter runs reload..0, i.e. half_cycles states.
    function automatic half_t half_reload(input note_t n);
        return half_cycles(n) - 17'd1;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// -----------------------------------------------------------------------------
// tone_divider
// Reloadable 17-bit half-period down-counter with a toggling square output.
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   clr_i     : force counter to 0 and output low (highest priority)
//   load_i    : load reload_i and drive the output high (start of a tone)
//   run_i     : count down; at 0 reload and toggle the output
//   reload_i  : half-period length minus one
//   tone_o    : registered square-wave output
// -----------------------------------------------------------------------------
module tone_divider
    import note_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              run_i,
    input  logic [HALF_W-1:0] reload_i,
    output logic              tone_o
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clr_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (load_i) begin
            cnt_d  = reload_i;
            tone_d = 1'b1;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                cnt_d  = reload_i;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
// 16-slot note store written by the recorder controller, plus a tone FSM
// (IDLE / GAP / TONE) that plays the note at rd_addr as a square wave with a
// silent articulation gap at every note start.
//   clk          : 50 MHz system clock
//   reset        : synchronous active-high reset
//   ld_note      : record strobe; one write per rising edge
//   ld_play      : playback active level; blocks writes
//   note_in      : note code to record (0 rest, 1..7 = C4..B4)
//   wr_addr      : slot to record into
//   rd_addr      : slot to play
//   next_note_en : one-cycle note-advance pulse (restarts articulation)
//   audio_out    : square-wave speaker drive
//   cur_note     : registered note code being played (0 when not playing)
//   playing      : high in GAP or TONE
// -----------------------------------------------------------------------------
module note_player
    import note_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_note,
    input  logic              ld_play,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              next_note_en,
    output logic              audio_out,
    output logic [NOTE_W-1:0] cur_note,
    output logic              playing
);

    // A zero gap still costs one silent cycle.
    localparam int unsigned      GAP_EFF  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned      GAP_W    = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);

    // ---------------------------------------------------------------- store
    note_t mem_q [DEPTH];
    logic  ld_note_q;
    logic  armed_q;     // set once ld_note has been seen low after reset
    logic  wr_en;

    // A key already held when reset releases must not record: the rising
    // edge only counts after ld_note has been sampled low at least once.
    assign wr_en = ld_note && !ld_note_q && armed_q && !ld_play;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOTE_REST;
            end
            ld_note_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            ld_note_q <= ld_note;
            if (!ld_note) begin
                armed_q <= 1'b1;
            end
            if (wr_en) begin
                mem_q[wr_addr] <= note_in;
            end
        end
    end

    // -------------------------------------------------------- current note
    note_t cur_note_q, cur_note_d;
    note_t cur_prev_q;
    logic  ld_play_q;

    assign cur_note_d = ld_play ? mem_q[rd_addr] : NOTE_REST;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_note_q <= NOTE_REST;
            cur_prev_q <= NOTE_REST;
            ld_play_q  <= 1'b0;
        end else begin
            cur_note_q <= cur_note_d;
            cur_prev_q <= cur_note_q;
            ld_play_q  <= ld_play;
        end
    end

    // ------------------------------------------------------------ tone FSM
    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             start_evt;
    logic             play_fall;
    logic             div_clr, div_load, div_run;
    logic             tone;

    assign start_evt = (cur_note_q != cur_prev_q) || (next_note_en && ld_play);
    assign play_fall = ld_play_q && !ld_play;

    // The divider is steered from the next-state decision so that audio_out
    // comes straight from a register and changes on the same edge as state.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        div_clr  = 1'b0;
        div_load = 1'b0;
        div_run  = 1'b0;
        if (play_fall) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            div_clr = 1'b1;
        end else if (start_evt) begin
            div_clr = 1'b1;
            if (cur_note_q != NOTE_REST) begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end else begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_clr = 1'b1;
                    if (ld_play && (cur_note_q != NOTE_REST)) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_d  = ST_TONE;
                        div_load = 1'b1;
                    end else begin
                        gap_d   = gap_q - 1'b1;
                        div_clr = 1'b1;
                    end
                end
                ST_TONE: begin
                    div_run = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                    div_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    tone_divider u_div (
        .clk_i    (clk),
        .reset_i  (reset),
        .clr_i    (div_clr),
        .load_i   (div_load),
        .run_i    (div_run),
        .reload_i (half_reload(cur_note_q)),
        .tone_o   (tone)
    );

    assign audio_out = tone;
    assign cur_note  = cur_note_q;
    assign playing   = (state_q != ST_IDLE);

endmodule
